// File: rtl/pw_capture_sequencer.sv
// pw_capture_sequencer: arm/flush/armed/capture/done sequencer for the sniff
// capture datapath, with a delayed trigger pulse launched on the pattern match.
// Optional feature: define PW_SEQ_TIMEOUT_EN to add an ARMED-state timeout
// (I_timeout / O_timeout ports and the ARMED cycle counter).
// Handshake note: there is no valid/ready pair here; I_arm is a level whose
// rising edge starts a capture and whose low level aborts it, and every
// output is a flop updated one cycle after the input that caused it.
module pw_capture_sequencer #(
  parameter int pCAPTURE_LEN_WIDTH   = 16,
  parameter int pTRIGGER_DELAY_WIDTH = 20,
`ifdef PW_SEQ_TIMEOUT_EN
  parameter int pTIMEOUT_WIDTH       = 32,
`endif
  parameter int pTRIGGER_WIDTH_WIDTH = 16
) (
  input  logic                            fe_clk,
  input  logic                            reset_n,
  input  logic                            I_arm,
  input  logic                            I_flush_done,
  input  logic                            I_match,
  input  logic [pCAPTURE_LEN_WIDTH-1:0]   I_capture_len,
  input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delay,
  input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_width,
  input  logic                            I_data_wr,
  input  logic                            I_fifo_full,
`ifdef PW_SEQ_TIMEOUT_EN
  input  logic [pTIMEOUT_WIDTH-1:0]       I_timeout,
  output logic                            O_timeout,
`endif
  output logic                            O_flush_req,
  output logic                            O_armed,
  output logic                            O_capture_en,
  output logic                            O_trigger,
  output logic                            O_done,
  output logic                            O_overflow,
  output logic [2:0]                      O_state,
  output logic [pCAPTURE_LEN_WIDTH-1:0]   O_captured_count
);

  localparam int LW  = pCAPTURE_LEN_WIDTH;
  // Shared delay/pulse counter sized for the wider of the two settings.
  localparam int TCW = (pTRIGGER_DELAY_WIDTH > pTRIGGER_WIDTH_WIDTH) ?
                       pTRIGGER_DELAY_WIDTH : pTRIGGER_WIDTH_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FLUSH = 3'd1, S_ARMED = 3'd2, S_CAPTURE = 3'd3, S_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_DELAY = 2'd1, T_PULSE = 2'd2} trig_e;

  state_e                  state_q, state_d;
  trig_e                   trig_q, trig_d;
  logic                    arm_prev_q, arm_prev_d;
  logic [TCW-1:0]          tcnt_q, tcnt_d;
  logic [LW-1:0]           len_q, len_d;
  logic [TCW-1:0]          delay_q, delay_d;
  logic [TCW-1:0]          width_q, width_d;
  logic [LW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    flush_req_q, flush_req_d;
  logic                    armed_q, armed_d;
  logic                    capture_en_q, capture_en_d;
  logic                    trigger_q, trigger_d;
  logic                    done_q, done_d;
  logic                    match_take;
`ifdef PW_SEQ_TIMEOUT_EN
  logic [pTIMEOUT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                      timeout_q, timeout_d;
`endif

  // Main sequencer: next state, sticky flags, capture counter and config sampling.
  always_comb begin
    state_d    = state_q;
    arm_prev_d = I_arm;
    len_d      = len_q;
    delay_d    = delay_q;
    width_d    = width_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    match_take = 1'b0;
`ifdef PW_SEQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (I_arm && !arm_prev_q) begin
          state_d    = S_FLUSH;
          overflow_d = 1'b0;
          count_d    = '0;
`ifdef PW_SEQ_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
        end
      end
      S_FLUSH: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (I_flush_done) begin
          state_d = S_ARMED;
`ifdef PW_SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_ARMED: begin
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if (I_match) begin
          state_d    = S_CAPTURE;
          match_take = 1'b1;
          len_d      = I_capture_len;
          delay_d    = TCW'(I_trigger_delay);
          width_d    = TCW'(I_trigger_width);
        end else begin
`ifdef PW_SEQ_TIMEOUT_EN
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + pTIMEOUT_WIDTH'(1);
          if ((I_timeout != '0) && (to_cnt_d == I_timeout)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      S_CAPTURE: begin
        // A strobe into a full FIFO is flagged and dropped, never counted.
        if (I_data_wr) begin
          if (I_fifo_full) overflow_d = 1'b1;
          else if (count_q != '1) count_d = count_q + LW'(1);
        end
        if (!I_arm) begin
          state_d = S_IDLE;
        end else if ((len_q != '0) && (count_d == len_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!I_arm) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Trigger sub-FSM: counts the delay from the match, then holds the pulse.
  always_comb begin
    trig_d = trig_q;
    tcnt_d = tcnt_q;
    if (!I_arm) begin
      trig_d = T_IDLE;
      tcnt_d = '0;
    end else begin
      case (trig_q)
        T_IDLE: begin
          if (match_take && (I_trigger_width != '0)) begin
            trig_d = (I_trigger_delay == '0) ? T_PULSE : T_DELAY;
            tcnt_d = TCW'(1);
          end
        end
        T_DELAY: begin
          if (tcnt_q == delay_q) begin
            trig_d = T_PULSE;
            tcnt_d = TCW'(1);
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        T_PULSE: begin
          if (tcnt_q == width_q) begin
            trig_d = T_IDLE;
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        default: begin
          trig_d = T_IDLE;
          tcnt_d = '0;
        end
      endcase
    end
  end

  // Output decode from next state so every output is a flop aligned with state.
  always_comb begin
    flush_req_d  = (state_d == S_FLUSH);
    armed_d      = (state_d == S_ARMED);
    capture_en_d = (state_d == S_CAPTURE);
    done_d       = (state_d == S_DONE);
    trigger_d    = (trig_d == T_PULSE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      trig_q       <= T_IDLE;
      arm_prev_q   <= 1'b0;
      tcnt_q       <= '0;
      len_q        <= '0;
      delay_q      <= '0;
      width_q      <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      flush_req_q  <= 1'b0;
      armed_q      <= 1'b0;
      capture_en_q <= 1'b0;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
`ifdef PW_SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      arm_prev_q   <= arm_prev_d;
      tcnt_q       <= tcnt_d;
      len_q        <= len_d;
      delay_q      <= delay_d;
      width_q      <= width_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      flush_req_q  <= flush_req_d;
      armed_q      <= armed_d;
      capture_en_q <= capture_en_d;
      trigger_q    <= trigger_d;
      done_q       <= done_d;
`ifdef PW_SEQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign O_flush_req      = flush_req_q;
  assign O_armed          = armed_q;
  assign O_capture_en     = capture_en_q;
  assign O_trigger        = trigger_q;
  assign O_done           = done_q;
  assign O_overflow       = overflow_q;
  assign O_state          = state_q;
  assign O_captured_count = count_q;
`ifdef PW_SEQ_TIMEOUT_EN
  assign O_timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_pw_capture_sequencer.sv
// Bench for pw_capture_sequencer: directed steps plus randomized captures
// checked against a cycle-indexed reference model of the capture rules.
module tb_pw_capture_sequencer;
  localparam int LW = 16;
  localparam int DW = 20;
  localparam int WW = 16;

  logic          fe_clk = 1'b0;
  logic          reset_n;
  logic          I_arm, I_flush_done, I_match, I_data_wr, I_fifo_full;
  logic [LW-1:0] I_capture_len;
  logic [DW-1:0] I_trigger_delay;
  logic [WW-1:0] I_trigger_width;
  logic          O_flush_req, O_armed, O_capture_en, O_trigger, O_done, O_overflow;
  logic [2:0]    O_state;
  logic [LW-1:0] O_captured_count;
`ifdef PW_SEQ_TIMEOUT_EN
  logic [31:0]   I_timeout;
  logic          O_timeout;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [0:0] exp_q[$];     // expected trigger level per cycle after the match
  int m_count;
  logic m_overflow;

  pw_capture_sequencer dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_arm(I_arm), .I_flush_done(I_flush_done),
    .I_match(I_match), .I_capture_len(I_capture_len), .I_trigger_delay(I_trigger_delay),
    .I_trigger_width(I_trigger_width), .I_data_wr(I_data_wr), .I_fifo_full(I_fifo_full),
`ifdef PW_SEQ_TIMEOUT_EN
    .I_timeout(I_timeout), .O_timeout(O_timeout),
`endif
    .O_flush_req(O_flush_req), .O_armed(O_armed), .O_capture_en(O_capture_en),
    .O_trigger(O_trigger), .O_done(O_done), .O_overflow(O_overflow),
    .O_state(O_state), .O_captured_count(O_captured_count)
  );

  // Clock
  always #5 fe_clk = ~fe_clk;

  task automatic tick;
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(O_state), 32'd0);
    chk({tag, "_flush"}, 32'(O_flush_req), 32'd0);
    chk({tag, "_armed"}, 32'(O_armed), 32'd0);
    chk({tag, "_cap_en"}, 32'(O_capture_en), 32'd0);
    chk({tag, "_trig"}, 32'(O_trigger), 32'd0);
    chk({tag, "_done"}, 32'(O_done), 32'd0);
    chk({tag, "_ovf"}, 32'(O_overflow), 32'd0);
    chk({tag, "_count"}, 32'(O_captured_count), 32'd0);
  endtask

  // Arm edge followed by n FLUSH cycles (flush_done rises in the last one).
  task automatic arm_flush(input int n);
    I_arm = 1'b1;
    I_flush_done = 1'b0;
    tick();
    chk("arm_ovf_clr", 32'(O_overflow), 32'd0);
    chk("arm_cnt_clr", 32'(O_captured_count), 32'd0);
    m_count = 0;
    m_overflow = 1'b0;
    for (int i = 1; i <= n; i++) begin
      I_flush_done = (i == n);
      chk("flush_req", 32'(O_flush_req), 32'd1);
      chk("flush_state", 32'(O_state), 32'd1);
      tick();
    end
    I_flush_done = 1'b0;
    chk("armed", 32'(O_armed), 32'd1);
    chk("armed_state", 32'(O_state), 32'd2);
    chk("armed_flush_lo", 32'(O_flush_req), 32'd0);
  endtask

  // Match (cycle 0) then n cycles of capture, each checked against the model.
  // mode 0: random strobes/full; 1: strobes in cycles 1..6; 2: strobes, full on 2nd.
  task automatic run_capture(input int d, input int w, input int len, input int mode, input int n);
    logic in_cap, m_done, wr, full;
    exp_q.delete();
    for (int k = 1; k <= n; k++) exp_q.push_back(1'((w != 0) && (k > d) && (k <= d + w)));
    in_cap = 1'b0;
    m_done = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        I_match = 1'b1;
        I_capture_len = LW'(len);
        I_trigger_delay = DW'(d);
        I_trigger_width = WW'(w);
        wr = 1'b1;
        full = 1'b0;
      end else begin
        I_match = ($urandom_range(0, 3) == 0);
        I_capture_len = LW'($urandom_range(0, 3));
        I_trigger_delay = DW'($urandom_range(0, 3));
        I_trigger_width = WW'($urandom_range(0, 3));
        case (mode)
          1: begin wr = (c <= 6); full = 1'b0; end
          2: begin wr = 1'b1; full = (c == 2); end
          default: begin wr = ($urandom_range(0, 3) != 0); full = ($urandom_range(0, 5) == 0); end
        endcase
      end
      I_data_wr = wr;
      I_fifo_full = full;
      if (c == 0) begin
        in_cap = 1'b1;
      end else if (in_cap && wr) begin
        if (full) m_overflow = 1'b1;
        else if (m_count < 65535) m_count++;
        if (len != 0 && m_count == len) begin
          in_cap = 1'b0;
          m_done = 1'b1;
        end
      end
      tick();
      chk("cap_state", 32'(O_state), m_done ? 32'd4 : 32'd3);
      chk("cap_en", 32'(O_capture_en), 32'(in_cap));
      chk("cap_done", 32'(O_done), 32'(m_done));
      chk("cap_count", 32'(O_captured_count), 32'(m_count));
      chk("cap_ovf", 32'(O_overflow), 32'(m_overflow));
      chk("cap_trig", 32'(O_trigger), 32'(exp_q.pop_front()));
    end
    I_match = 1'b0;
    I_data_wr = 1'b0;
    I_fifo_full = 1'b0;
  endtask

  task automatic disarm;
    I_arm = 1'b0;
    tick();
    chk("disarm_state", 32'(O_state), 32'd0);
    chk("disarm_trig", 32'(O_trigger), 32'd0);
    chk("disarm_done", 32'(O_done), 32'd0);
    chk("disarm_ovf", 32'(O_overflow), 32'(m_overflow));
    chk("disarm_count", 32'(O_captured_count), 32'(m_count));
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    I_arm = 1'b0; I_flush_done = 1'b0; I_match = 1'b0; I_data_wr = 1'b0; I_fifo_full = 1'b0;
    I_capture_len = '0; I_trigger_delay = '0; I_trigger_width = '0;
`ifdef PW_SEQ_TIMEOUT_EN
    I_timeout = '0;
`endif
    m_count = 0;
    m_overflow = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Flush held 5 cycles, then delay=3 width=2, len=4 with 6 strobes
    arm_flush(5);
    run_capture(3, 2, 4, 1, 8);
    disarm();

    // Full FIFO on the 2nd strobe; then re-arm clears the flag
    arm_flush(1);
    run_capture(0, 0, 4, 2, 8);
    chk("ovf_seen", 32'(O_overflow), 32'd1);
    disarm();
    arm_flush(2);
    chk("rearm_ovf", 32'(O_overflow), 32'd0);

    // Disarm at cycle 2 of a 10-cycle delay: trigger never fires
    I_trigger_delay = DW'(10); I_trigger_width = WW'(3); I_capture_len = LW'(0);
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    tick();
    I_arm = 1'b0;
    tick();
    chk("abort_state", 32'(O_state), 32'd0);
    for (int i = 0; i < 14; i++) begin
      chk("abort_trig", 32'(O_trigger), 32'd0);
      tick();
    end

    // Disarm beats a simultaneous match
    arm_flush(1);
    I_arm = 1'b0;
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    chk("disarm_vs_match_state", 32'(O_state), 32'd0);
    chk("disarm_vs_match_cap", 32'(O_capture_en), 32'd0);

    // Reset in the middle of a capture with the pulse and overflow active
    arm_flush(2);
    I_trigger_delay = DW'(0); I_trigger_width = WW'(5); I_capture_len = LW'(0);
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    I_data_wr = 1'b1; I_fifo_full = 1'b1;
    tick();
    I_fifo_full = 1'b0;
    tick();
    I_data_wr = 1'b0;
    chk("mid_trig", 32'(O_trigger), 32'd1);
    chk("mid_ovf", 32'(O_overflow), 32'd1);
    chk("mid_count", 32'(O_captured_count), 32'd1);
    reset_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    I_arm = 1'b0;
    reset_n = 1'b1;
    tick();
    m_count = 0;
    m_overflow = 1'b0;

    // Randomized captures
    for (int r = 0; r < 10; r++) begin
      arm_flush($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("armed_wait", 32'(O_armed), 32'd1);
      end
      run_capture($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 7), 0, 14);
      disarm();
    end

`ifdef PW_SEQ_TIMEOUT_EN
    // ARMED timeout after 10 cycles; zero timeout waits; match beats timeout
    I_timeout = 32'd10;
    arm_flush(1);
    repeat (9) tick();
    chk("to_still_armed", 32'(O_state), 32'd2);
    tick();
    chk("to_done_state", 32'(O_state), 32'd4);
    chk("to_flag", 32'(O_timeout), 32'd1);
    chk("to_trig", 32'(O_trigger), 32'd0);
    disarm();
    I_timeout = 32'd0;
    arm_flush(1);
    repeat (30) tick();
    chk("to_zero_armed", 32'(O_state), 32'd2);
    chk("to_zero_flag", 32'(O_timeout), 32'd0);
    disarm();
    I_timeout = 32'd3;
    arm_flush(1);
    repeat (2) tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    chk("to_match_wins", 32'(O_state), 32'd3);
    chk("to_match_flag", 32'(O_timeout), 32'd0);
    disarm();
    I_timeout = 32'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
